// File: rtl/int_mult_ctrl.sv
// int_mult_ctrl: front end for a fixed-latency unsigned multiplier.
// Converts signed operands to magnitudes, tracks the sign and tag of every
// operand pair through the multiplier latency, restores the sign of the
// product and buffers results in a credit-protected first-word-fall-through
// FIFO. The multiplier itself never stalls.
module int_mult_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MULT_LAT   = 5,
    parameter int OUT_DEPTH  = 8,
    parameter int TAG_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_signed,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      mult_en,
    output logic [DATA_WIDTH-1:0]     mult_cand,
    output logic [DATA_WIDTH-1:0]     mult_plier,
    input  logic [2*DATA_WIDTH-1:0]   mult_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    localparam logic [DATA_WIDTH-1:0] D_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] D_ONE    = DATA_WIDTH'(1'b1);
    localparam logic [PW-1:0]         P_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0]         P_ONE    = PW'(1'b1);
    localparam logic [TAG_W-1:0]      T_ZERO   = {TAG_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W:0]        DEPTH_L  = (CNT_W + 1)'(OUT_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(OUT_DEPTH - 1);

    // Magnitude of an operand; the most-negative value maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DATA_WIDTH-1:0] magnitude(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  is_signed
    );
        if (is_signed && v[DATA_WIDTH-1]) begin
            magnitude = ~v + D_ONE;
        end else begin
            magnitude = v;
        end
    endfunction

    // Two's-complement negation of a full-width product (0 stays 0).
    function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
        negate = ~v + P_ONE;
    endfunction

    // Circular FIFO pointer advance.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            ptr_inc = PTR_ZERO;
        end else begin
            ptr_inc = p + PTR_ONE;
        end
    endfunction

    // Operand stage and latency tracking
    logic                 op_vld_r;
    logic                 op_neg_r;
    logic [TAG_W-1:0]     op_tag_r;
    logic [DATA_WIDTH-1:0] cand_r;
    logic [DATA_WIDTH-1:0] plier_r;
    logic [MULT_LAT-1:0]  sr_vld_r;
    logic                 sr_neg_r [MULT_LAT];
    logic [TAG_W-1:0]     sr_tag_r [MULT_LAT];

    // FIFO and credit state
    logic [PW-1:0]        fifo_res_r [OUT_DEPTH];
    logic [TAG_W-1:0]     fifo_tag_r [OUT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     inflight_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [PW-1:0]        out_result_r;
    logic [TAG_W-1:0]     out_tag_r;

    // Combinational next-state
    logic                 accept_s;
    logic                 wr_s;
    logic                 pop_s;
    logic [PW-1:0]        wr_res_s;
    logic [TAG_W-1:0]     wr_tag_s;
    logic [CNT_W-1:0]     inflight_nxt_s;
    logic [CNT_W-1:0]     count_nxt_s;
    logic [CNT_W-1:0]     rem_s;
    logic [CNT_W:0]       credit_sum_s;
    logic [PTR_W-1:0]     wr_ptr_nxt_s;
    logic [PTR_W-1:0]     rd_ptr_nxt_s;
    logic                 in_ready_nxt_s;
    logic [PW-1:0]        head_res_s;
    logic [TAG_W-1:0]     head_tag_s;

    // Reset forces in_ready and mult_en low immediately; the credit register
    // itself resets to 1 so requests are taken in the first cycle after reset.
    assign in_ready   = in_ready_r & ~rst;
    assign mult_en    = ~rst;
    assign mult_cand  = cand_r;
    assign mult_plier = plier_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_tag    = out_tag_r;

    assign accept_s = in_valid & in_ready;
    assign wr_s     = sr_vld_r[MULT_LAT-1];
    assign pop_s    = out_valid_r & out_ready;
    assign wr_tag_s = sr_tag_r[MULT_LAT-1];
    assign wr_res_s = sr_neg_r[MULT_LAT-1] ? negate(mult_result) : mult_result;

    // Capture operand magnitudes, sign and tag on accept; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_vld_r <= 1'b0;
            op_neg_r <= 1'b0;
            op_tag_r <= T_ZERO;
            cand_r   <= D_ZERO;
            plier_r  <= D_ZERO;
        end else begin
            op_vld_r <= accept_s;
            if (accept_s) begin
                op_neg_r <= in_signed & (in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1]);
                op_tag_r <= in_tag;
                cand_r   <= magnitude(in_a, in_signed);
                plier_r  <= magnitude(in_b, in_signed);
            end else begin
                op_neg_r <= op_neg_r;
                op_tag_r <= op_tag_r;
                cand_r   <= cand_r;
                plier_r  <= plier_r;
            end
        end
    end

    // Shift valid/neg/tag alongside the multiplier pipeline every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                sr_vld_r[i] <= 1'b0;
                sr_neg_r[i] <= 1'b0;
                sr_tag_r[i] <= T_ZERO;
            end
        end else begin
            sr_vld_r[0] <= op_vld_r;
            sr_neg_r[0] <= op_neg_r;
            sr_tag_r[0] <= op_tag_r;
            for (int i = 1; i < MULT_LAT; i++) begin
                sr_vld_r[i] <= sr_vld_r[i-1];
                sr_neg_r[i] <= sr_neg_r[i-1];
                sr_tag_r[i] <= sr_tag_r[i-1];
            end
        end
    end

    // Next counts, pointers, credit and the FIFO head seen after this edge.
    always_comb begin
        inflight_nxt_s = inflight_r;
        count_nxt_s    = count_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        head_res_s     = P_ZERO;
        head_tag_s     = T_ZERO;

        case ({accept_s, wr_s})
            2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
            2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
            default: inflight_nxt_s = inflight_r;
        endcase

        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        if (wr_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // Entries left after the pop; if none, the new head is the word
        // being written this cycle and must bypass the storage array.
        rem_s = count_r - (pop_s ? CNT_ONE : CNT_ZERO);

        if (count_nxt_s == CNT_ZERO) begin
            head_res_s = P_ZERO;
            head_tag_s = T_ZERO;
        end else if (wr_s && (rem_s == CNT_ZERO)) begin
            head_res_s = wr_res_s;
            head_tag_s = wr_tag_s;
        end else begin
            head_res_s = fifo_res_r[rd_ptr_nxt_s];
            head_tag_s = fifo_tag_r[rd_ptr_nxt_s];
        end

        credit_sum_s   = {1'b0, inflight_nxt_s} + {1'b0, count_nxt_s};
        in_ready_nxt_s = (credit_sum_s < DEPTH_L);
    end

    // FIFO storage write; contents need no reset since the pointers gate use.
    always_ff @(posedge clk) begin
        if (!rst && wr_s) begin
            fifo_res_r[wr_ptr_r] <= wr_res_s;
            fifo_tag_r[wr_ptr_r] <= wr_tag_s;
        end
    end

    // Register counts, pointers, credit and the FIFO head outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r   <= CNT_ZERO;
            count_r      <= CNT_ZERO;
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_result_r <= P_ZERO;
            out_tag_r    <= T_ZERO;
        end else begin
            inflight_r   <= inflight_nxt_s;
            count_r      <= count_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
            out_valid_r  <= (count_nxt_s != CNT_ZERO);
            out_result_r <= head_res_s;
            out_tag_r    <= head_tag_s;
        end
    end

endmodule

// File: tb/tb_int_mult_ctrl.sv
// Testbench for int_mult_ctrl: a behavioural multiplier drives mult_result,
// a queue-based model predicts handshake and result outputs every cycle, and
// directed scenarios pin literal expectations.
module tb_int_mult_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 5;
    localparam int DEP = 8;
    localparam int TW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_signed;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic [TW-1:0]   in_tag;
    logic            mult_en;
    logic [DW-1:0]   mult_cand;
    logic [DW-1:0]   mult_plier;
    logic [2*DW-1:0] mult_result;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_result;
    logic [TW-1:0]   out_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_mult_ctrl #(.DATA_WIDTH(DW), .MULT_LAT(LAT), .OUT_DEPTH(DEP), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mult_en(mult_en), .mult_cand(mult_cand), .mult_plier(mult_plier),
        .mult_result(mult_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    // Behavioural unsigned multiplier: result visible LAT cycles after operands.
    logic [2*DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {32'h0, mult_cand} * {32'h0, mult_plier};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mult_result = pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({32'h0, a} * {32'h0, b});
        return p;
    endfunction

    // Model: every accepted request is outstanding until popped; it becomes
    // visible at the head after edge (accept edge + 1 + LAT).
    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
        int          wedge;
    } item_t;

    item_t q[$];
    int    cyc = 0;

    always @(posedge clk) begin : model_upd
        bit acc;
        bit pop_now;
        cyc++;
        pop_now = (q.size() > 0) && (q[0].wedge <= cyc - 1) && out_ready;
        acc     = in_valid && !rst && (q.size() < DEP);
        if (rst) begin
            q.delete();
        end else begin
            if (pop_now) void'(q.pop_front());
            if (acc) q.push_back('{model_prod(in_signed, in_a, in_b), in_tag, cyc + 1 + LAT});
        end
    end

    // Compare DUT outputs with the model on every cycle after the first edge.
    always @(negedge clk) begin : compare
        bit ev;
        if (cyc > 0) begin
            ev = (q.size() > 0) && (q[0].wedge <= cyc);
            chk("in_ready", in_ready, (!rst && q.size() < DEP));
            chk("mult_en", mult_en, !rst);
            chk("out_valid", out_valid, ev);
            if (ev) begin
                chk("out_result", out_result, q[0].res);
                chk("out_tag", out_tag, q[0].tag);
            end
        end
    end

    task automatic single(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [63:0] exp_res, input string name);
        int lat;
        bit seen;
        @(posedge clk); #1;
        in_valid = 1'b1; in_signed = s; in_a = a; in_b = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else lat++;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_latency"}, 64'(lat), 64'd6);
            chk({name, "_result"}, out_result, exp_res);
            chk({name, "_tag"}, out_tag, tag);
        end
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int acc;
        int n;
        int vcnt;
        int runs;
        bit prev;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_a = 32'h0; in_b = 32'h0;
        in_tag = 4'h0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mult_en", mult_en, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 64'h0);
        chk("rst_out_tag", out_tag, 4'h0);
        chk("rst_mult_cand", mult_cand, 32'h0);
        chk("rst_mult_plier", mult_plier, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1'b1);

        // Directed products
        single(1'b0, 32'd7,         32'd6,         4'd3, 64'd42,                  "u7x6");
        single(1'b1, 32'hFFFF_FFFD, 32'd5,         4'd1, 64'hFFFF_FFFF_FFFF_FFF1, "sm3x5");
        single(1'b1, 32'd0,         32'hFFFF_FFFF, 4'd2, 64'h0,                   "s0xm1");
        single(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd4, 64'h4000_0000_0000_0000, "sminxmin");
        single(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 64'hFFFF_FFFE_0000_0001, "umaxsq");
        single(1'b1, 32'h8000_0000, 32'd1,         4'd6, 64'hFFFF_FFFF_8000_0000, "sminx1");
        single(1'b1, 32'd5,         32'hFFFF_FFFD, 4'd7, 64'hFFFF_FFFF_FFFF_FFF1, "s5xm3");

        // Backpressure: 10 requests with out_ready low
        @(posedge clk); #1;
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_signed = 1'b0; in_tag = 4'(i);
            in_a = 32'(i + 1); in_b = 32'(i + 3);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepts", 64'(acc), 64'd8);
        repeat (10) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1; n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("bp_tag_order", out_tag, 4'(n));
                n++;
            end
        end
        chk("bp_results", 64'(n), 64'd8);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        chk("bp_in_ready_back", seen, 1'b1);

        // Reset mid-flight: three accepts then a one-cycle reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_signed = 1'b0; in_a = 32'(10 + i); in_b = 32'd3; in_tag = 4'(9 + i);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        vcnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("rst_mid_discard", 64'(vcnt), 64'd0);

        // Throughput: 20 back-to-back requests with out_ready high
        acc = 0; vcnt = 0; runs = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i < 20) begin
                in_valid  = 1'b1;
                in_signed = i[0];
                in_a      = 32'(i * 37) ^ (i[1] ? 32'hFFFF_0000 : 32'h0);
                in_b      = 32'hFFFF_FFFF - 32'(i * 1001);
                in_tag    = 4'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 20 && in_ready) acc++;
            if (out_valid) begin
                vcnt++;
                if (!prev) runs++;
            end
            prev = out_valid;
        end
        chk("tp_accepts", 64'(acc), 64'd20);
        chk("tp_valid_cycles", 64'(vcnt), 64'd20);
        chk("tp_valid_runs", 64'(runs), 64'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
